fp_widen_stream: RTL
====================

Name: fp_widen_stream

Overview:
- Streaming IEEE754 widening converter, e.g. float16 to float32. It is the inverse direction of the team's narrowing fp_conv.
- Two-stage registered pipeline with valid/ready handshakes on both sides.
- Handles zero, subnormal, infinity and NaN exactly. Every narrow-format value maps to an exact wide-format value.
- Sits between float16 producers (e.g. narrowed FPU results) and float32 FPU consumers.

Parameters:
- INX, 5, input exponent width.
- INM, 10, input mantissa width.
- ONX, 8, output exponent width.
- ONM, 23, output mantissa width.
- CNTW, 16, statistics counter width (used only with the optional feature).
- Constraints: ONX > INX, ONM >= INM, and OXOFF - IXOFF - INM >= 1, where XOFF(n) = 2**(n-1) - 1. Elaboration must fail otherwise.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- IN_DATA  in  1+INX+INM  narrow float, packed {sign, exp, mant}.
- IN_VALID  in  1  input data valid.
- IN_READY  out  1  converter can accept input this cycle.
- OUT_DATA  out  1+ONX+ONM  wide float, packed {sign, exp, mant}.
- OUT_FLAGS  out  4  {is_nan, is_inf, is_zero, was_subnormal} of the input that produced OUT_DATA.
- OUT_VALID  out  1  output data valid.
- OUT_READY  in  1  downstream accepts output.
- Interface (decided): one clock, CLK; reset RST is synchronous and active-high.

Behaviour:
- Reset (RST high at a CLK edge):
  - Stage-1 and stage-2 valid bits clear, so OUT_VALID = 0.
  - OUT_DATA = 0 and OUT_FLAGS = 0.
  - Reset mid-stream discards in-flight items. No output is produced for them.
- Handshake:
  - An input transfer occurs when IN_VALID && IN_READY at the CLK edge.
  - An output transfer occurs when OUT_VALID && OUT_READY.
  - OUT_DATA and OUT_FLAGS are stable while OUT_VALID && !OUT_READY.
- Pipeline advance:
  - s2_adv = !s2_valid || OUT_READY.
  - s1_adv = !s1_valid || s2_adv.
  - IN_READY = s1_adv. This is combinational from OUT_READY; there is no skid buffer.
- Latency and throughput:
  - An item accepted at edge k is presented on OUT at edge k+2 if not stalled.
  - Throughput is 1 item per cycle.
  - Simultaneous input and output transfers in the same cycle are legal and sustain full rate.
  - Order is preserved; no item is dropped or duplicated.
- Stage 1 (register):
  - sign, exp, mant and the class: zero, subnormal, normal, inf, nan.
  - n = count of leading zeros of mant over INM bits. Only meaningful for subnormals.
- Stage 2 (register): compose the output fields as follows.
  - Normal input:
    - exp = in_exp - IXOFF + OXOFF.
    - mant = in_mant left-aligned in ONM bits (low bits zero).
  - Zero (exp = 0, mant = 0):
    - Output all zero except the sign.
    - is_zero = 1.
  - Subnormal (exp = 0, mant != 0):
    - exp = OXOFF - IXOFF - n.
    - mant = low INM bits of (in_mant << (n+1)), left-aligned.
    - was_subnormal = 1.
  - Infinity (exp all ones, mant = 0):
    - exp all ones, mant = 0, sign preserved.
    - is_inf = 1.
  - NaN (exp all ones, mant != 0):
    - exp all ones; mant = in_mant left-aligned, with the output mant MSB forced to 1 (quiet).
    - Sign preserved.
    - is_nan = 1.
- Exponent arithmetic is performed at ONX+1 bits. Given the parameter constraints, results never underflow or overflow.

Optional Feature:
- Macro FP_WIDEN_STATS_EN.
- When defined:
  - Adds output ports NAN_CNT [CNTW] and SUB_CNT [CNTW].
  - Each counter increments on an output transfer whose flag is_nan or was_subnormal is set, respectively.
  - Counters saturate at all ones.
  - Counters clear to 0 on RST.
- When undefined: the ports and counters do not exist; datapath behaviour is identical.

Test Plan:
- Reset, then stream IN_DATA 0x3C00, 0xC000, 0x8000 with OUT_READY = 1.
  - Outputs appear 2 cycles after each accept: 0x3F800000, 0xC0000000, 0x80000000.
  - Flags: 0, 0, is_zero.
- Subnormals 0x0001 and 0x0200 -> 0x33800000 and 0x38000000, each with was_subnormal = 1. With the macro defined, SUB_CNT = 2.
- Specials:
  - 0x7C00 -> 0x7F800000, is_inf.
  - 0xFC00 -> 0xFF800000, is_inf.
  - 0x7E01 -> 0x7FC02000, is_nan.
  - 0x7C01 -> 0x7FC02000, is_nan.
- Backpressure:
  - Hold OUT_READY = 0 and offer 0x3C00, 0x4000, 0x4200. The first two are accepted; IN_READY = 0 on the third. OUT_DATA holds 0x3F800000.
  - Release OUT_READY. Outputs are 0x3F800000, 0x40000000, 0x40400000 in that order, with one output per cycle.
- Reset mid-op: accept two items, assert RST for 1 cycle. OUT_VALID = 0 after the edge, and neither item ever appears. The next input converts normally.
- Counter saturation (macro defined, CNTW = 2): send 5 NaNs. NAN_CNT reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/fp_widen_stream_if.sv
// Stream bundle for fp_widen_stream: narrow input side, wide output side with class flags.
interface fp_widen_stream_if #(
    parameter int IW = 16,
    parameter int OW = 32
);
    logic [IW-1:0] IN_DATA;
    logic          IN_VALID;
    logic          IN_READY;
    logic [OW-1:0] OUT_DATA;
    logic [3:0]    OUT_FLAGS;
    logic          OUT_VALID;
    logic          OUT_READY;

    modport master (
        output IN_DATA, IN_VALID, OUT_READY,
        input  IN_READY, OUT_DATA, OUT_FLAGS, OUT_VALID
    );

    modport slave (
        input  IN_DATA, IN_VALID, OUT_READY,
        output IN_READY, OUT_DATA, OUT_FLAGS, OUT_VALID
    );
endinterface

// File: rtl/fp_widen_stream.sv
// Two-stage streaming IEEE754 widening converter (e.g. float16 -> float32), exact for all classes.
// Optional FP_WIDEN_STATS_EN adds saturating NaN / subnormal output counters NAN_CNT and SUB_CNT.
module fp_widen_stream #(
    parameter int INX  = 5,
    parameter int INM  = 10,
    parameter int ONX  = 8,
    parameter int ONM  = 23,
    parameter int CNTW = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    fp_widen_stream_if.slave      bus
`ifdef FP_WIDEN_STATS_EN
    ,
    output logic [CNTW-1:0]       NAN_CNT,
    output logic [CNTW-1:0]       SUB_CNT
`endif
);
    localparam int IW    = 1 + INX + INM;
    localparam int OW    = 1 + ONX + ONM;
    localparam int IXOFF = 2 ** (INX - 1) - 1;
    localparam int OXOFF = 2 ** (ONX - 1) - 1;
    localparam int NW    = $clog2(INM + 1);
    localparam logic signed [ONX:0] BIAS_D = (ONX + 1)'(OXOFF - IXOFF);

    if (ONX <= INX || ONM < INM || (OXOFF - IXOFF - INM) < 1 || CNTW < 1) begin : g_bad_params
        $error("fp_widen_stream: illegal parameter combination");
    end

    typedef enum logic [2:0] {C_ZERO, C_SUB, C_NORM, C_INF, C_NAN} cls_t;

    function automatic logic [NW-1:0] lzc(input logic [INM-1:0] m);
        logic [NW-1:0] c;
        c = NW'(INM);
        for (int i = 0; i < INM; i++) begin
            if (m[i]) c = NW'(INM - 1 - i);
        end
        return c;
    endfunction

    function automatic cls_t classify(input logic [INX-1:0] e, input logic [INM-1:0] m);
        cls_t c;
        if (e == '0)      c = (m == '0) ? C_ZERO : C_SUB;
        else if (&e)      c = (m == '0) ? C_INF : C_NAN;
        else              c = C_NORM;
        return c;
    endfunction

    // Returns {wide float, flags}; flags = {is_nan, is_inf, is_zero, was_subnormal}.
    function automatic logic [OW+3:0] compose(input logic s, input logic [INX-1:0] e,
                                              input logic [INM-1:0] m, input cls_t c,
                                              input logic [NW-1:0] n);
        logic signed [ONX:0] ex;
        logic [ONX-1:0]      oe;
        logic [ONM-1:0]      om;
        logic [INM-1:0]      sh;
        logic [3:0]          fl;
        ex = '0;
        oe = '0;
        om = '0;
        sh = '0;
        fl = '0;
        case (c)
            C_NORM: begin
                ex = $signed((ONX + 1)'(e)) + BIAS_D;
                oe = ex[ONX-1:0];
                om = ONM'(m) << (ONM - INM);
            end
            C_SUB: begin
                // Normalise: the leading one becomes the hidden bit.
                ex = BIAS_D - $signed((ONX + 1)'(n));
                sh = m << (n + 1'b1);
                oe = ex[ONX-1:0];
                om = ONM'(sh) << (ONM - INM);
                fl = 4'b0001;
            end
            C_INF: begin
                oe = '1;
                fl = 4'b0100;
            end
            C_NAN: begin
                oe = '1;
                om = (ONM'(m) << (ONM - INM)) | (ONM'(1) << (ONM - 1));
                fl = 4'b1000;
            end
            default: fl = 4'b0010;
        endcase
        return {s, oe, om, fl};
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic             vld_p1, vld_p2;
    logic             s1_adv, s2_adv;
    logic             sign_p1;
    logic [INX-1:0]   exp_p1;
    logic [INM-1:0]   mant_p1;
    cls_t             cls_p1;
    logic [NW-1:0]    lz_p1;
    logic [OW-1:0]    data_p2;
    logic [3:0]       flags_p2;
    logic [OW+3:0]    comp;

    assign s2_adv       = !vld_p2 || bus.OUT_READY;
    assign s1_adv       = !vld_p1 || s2_adv;
    assign bus.IN_READY = s1_adv;

    // Stage 1: split fields, classify, count leading zeros.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1 <= 1'b0;
        end else if (s1_adv) begin
            vld_p1 <= bus.IN_VALID;
        end
    end

    always_ff @(posedge CLK) begin
        if (s1_adv && bus.IN_VALID) begin
            sign_p1 <= bus.IN_DATA[IW-1];
            exp_p1  <= bus.IN_DATA[IW-2 -: INX];
            mant_p1 <= bus.IN_DATA[INM-1:0];
            cls_p1  <= classify(bus.IN_DATA[IW-2 -: INX], bus.IN_DATA[INM-1:0]);
            lz_p1   <= lzc(bus.IN_DATA[INM-1:0]);
        end
    end

    assign comp = compose(sign_p1, exp_p1, mant_p1, cls_p1, lz_p1);

    // Stage 2: composed wide word; output registers clear on reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p2   <= 1'b0;
            data_p2  <= '0;
            flags_p2 <= '0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2  <= comp[OW+3:4];
                flags_p2 <= comp[3:0];
            end
        end
    end

    assign bus.OUT_DATA  = data_p2;
    assign bus.OUT_FLAGS = flags_p2;
    assign bus.OUT_VALID = vld_p2;

`ifdef FP_WIDEN_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            NAN_CNT <= '0;
            SUB_CNT <= '0;
        end else if (vld_p2 && bus.OUT_READY) begin
            if (flags_p2[3]) NAN_CNT <= sat_inc(NAN_CNT);
            if (flags_p2[0]) SUB_CNT <= sat_inc(SUB_CNT);
        end
    end
`endif
endmodule
